ex_muldiv: RTL and testbench

Iterative unsigned multiply/divide unit in the EX stage of the pipelined RV32 core. It consumes operands, op select and destination tag as they leave the ID/EX pipeline register. It stalls the front of the pipeline while iterating, then returns a tagged result with a one-cycle completion pulse for the EX/MEM write-back path. It is the downstream consumer of the ID/EX register's data and control fields.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ex_muldiv.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the EX-stage multiply/divide unit
package cpu_pkg;

    localparam int XLEN = 32;

    // Quotient returned by DIVU when the divisor is zero
    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative unsigned MUL/MULHU/DIVU/REMU unit for the EX stage
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            regwrite_o
);
    import cpu_pkg::*;

    localparam int AW = 2 * XLEN + 1;

    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  opnd_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_out_q, rd_out_d;

    logic             accept;
    logic             div0;
    logic             last_iter;

    logic [XLEN-1:0]  acc_hi, acc_lo;
    logic             is_div;
    logic [XLEN+1:0]  add_a, add_b, add_sum;
    logic             sub_neg;
    logic [XLEN:0]    mul_upper;
    logic [XLEN-1:0]  div_rem;
    logic [AW-1:0]    acc_step;

    assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
    assign div0      = op_i[1] && (rs2_i == '0);
    assign last_iter = (state_q == ST_BUSY) && (cnt_q == CNT_W'(XLEN - 1));

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = div0 ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall_o    = accept || (state_q == ST_BUSY);
        done_o     = (state_q == ST_DONE) && !flush_i;
        regwrite_o = done_o;
        result_o   = result_q;
        rd_o       = rd_out_q;
    end

    // One adder serves both algorithms: add for multiply, subtract (a + ~b + 1) for divide.
    // The accumulator's top bit is the carry slot of the 65-bit {carry, hi, lo} register.
    assign acc_hi  = acc_q[2*XLEN-1:XLEN];
    assign acc_lo  = acc_q[XLEN-1:0];
    assign is_div  = op_q[1];
    assign add_a   = is_div ? acc_q[2*XLEN:XLEN-1] : {1'b0, acc_q[2*XLEN:XLEN]};
    assign add_b   = is_div ? ~{2'b00, opnd_q} : {2'b00, opnd_q};
    assign add_sum = add_a + add_b + {{(XLEN+1){1'b0}}, is_div};
    assign sub_neg = add_sum[XLEN+1];

    assign mul_upper = acc_lo[0] ? add_sum[XLEN:0] : {1'b0, acc_hi};
    // On a failed trial the shifted remainder is below the divisor, so its MSB is zero
    assign div_rem   = sub_neg ? {acc_hi[XLEN-2:0], acc_lo[XLEN-1]} : add_sum[XLEN-1:0];

    always_comb begin
        acc_step = '0;
        if (is_div) begin
            acc_step = {1'b0, div_rem, acc_lo[XLEN-2:0], ~sub_neg};
        end else begin
            acc_step = {1'b0, mul_upper, acc_lo[XLEN-1:1]};
        end
    end

    // Datapath next state
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (div0) begin
                        // Park both answers so the usual hi/lo selection applies
                        acc_d    = {1'b0, rs1_i, XLEN'(DIV0_QUOT)};
                        result_d = op_i[0] ? rs1_i : XLEN'(DIV0_QUOT);
                        rd_out_d = rd_i;
                    end else begin
                        acc_d = {1'b0, {XLEN{1'b0}}, op_i[1] ? rs1_i : rs2_i};
                    end
                end
            end
            ST_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_iter && !flush_i) begin
                    result_d = op_q[0] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
                    rd_out_d = rd_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= MD_MUL;
            opnd_q   <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            if (accept) begin
                op_q   <= md_op_e'(op_i);
                opnd_q <= op_i[1] ? rs2_i : rs1_i;
                rd_q   <= rd_i;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        regwrite_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o),
        .regwrite_o (regwrite_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        start_i = 1'b0;
        op_i    = 2'b00;
        rs1_i   = '0;
        rs2_i   = '0;
        rd_i    = '0;
    endtask

    // Issue one op at cycle 0 and watch 40 cycles; optionally pulse start again at poke_cyc
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_cyc, input int poke_cyc);
        int          done_cyc = -1;
        int          ndone    = 0;
        bit          stall_ok = 1'b1;
        logic [31:0] res_seen = '0;
        logic [4:0]  rd_seen  = '0;
        logic        rw_seen  = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        rd_i    = rd;
        #1;
        check({tag, "_stall_c0"}, 64'(stall_o), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res_seen = result_o;
                    rd_seen  = rd_o;
                    rw_seen  = regwrite_o;
                end
                ndone++;
            end
            if (stall_o !== (c < exp_cyc)) stall_ok = 1'b0;
            clear_inputs();
            if (c == poke_cyc) begin
                start_i = 1'b1;
                op_i    = 2'b10;
                rs1_i   = 32'd100;
                rs2_i   = 32'd0;
                rd_i    = 5'd9;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_result"}, 64'(res_seen), 64'(exp));
        check({tag, "_rd"}, 64'(rd_seen), 64'(rd));
        check({tag, "_regwrite"}, 64'(rw_seen), 64'd1);
        check({tag, "_stall_profile"}, 64'(stall_ok), 64'd1);
        check({tag, "_result_hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int ndone;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_rd", 64'(rd_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_regwrite", 64'(regwrite_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        rst_i = 1'b0;

        run_op("mul_7x6",    2'b00, 32'd7,         32'd6,         5'd5,  32'd42,        33, 0);
        run_op("mulhu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, 0);
        run_op("mul_max",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001, 33, 0);
        run_op("divu_100_7", 2'b10, 32'd100,       32'd7,         5'd8,  32'd14,        33, 0);
        run_op("remu_100_7", 2'b11, 32'd100,       32'd7,         5'd10, 32'd2,         33, 0);
        run_op("remu_5_9",   2'b11, 32'd5,         32'd9,         5'd12, 32'd5,         33, 0);
        run_op("divu_by0",   2'b10, 32'd77,        32'd0,         5'd13, 32'hFFFF_FFFF, 1,  0);
        run_op("remu_by0",   2'b11, 32'h1234,      32'd0,         5'd14, 32'h1234,      1,  0);

        // Flush in BUSY at cycle 10
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd4;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            clear_inputs();
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_stall_c11", 64'(stall_o), 64'd0);
        check("flush_done_c11", 64'(done_o), 64'd0);
        flush_i = 1'b0;
        ndone = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_result_hold", 64'(result_o), 64'h1234);

        // start and flush together in IDLE
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; rs1_i = 32'd5; rs2_i = 32'd5; rd_i = 5'd2;
        #1;
        check("startflush_stall_c0", 64'(stall_o), 64'd0);
        @(negedge clk_i);
        check("startflush_stall_c1", 64'(stall_o), 64'd0);
        clear_inputs();
        flush_i = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        check("startflush_no_done", 64'(ndone), 64'd0);

        // Reset mid-operation at cycle 15
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd11;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_i);
            clear_inputs();
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_result", 64'(result_o), 64'd0);
        check("rst_mid_rd", 64'(rd_o), 64'd0);
        check("rst_mid_done", 64'(done_o), 64'd0);
        check("rst_mid_regwrite", 64'(regwrite_o), 64'd0);
        check("rst_mid_stall", 64'(stall_o), 64'd0);
        rst_i = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        check("rst_mid_no_done", 64'(ndone), 64'd0);

        // start pulsed during BUSY must be ignored
        run_op("busy_start", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 33, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
